// File: rtl/maze_step_unit.sv
// Maze walker: tracks a registered {X,Y} location and records accepted moves on a LIFO.
// Pops undo the most recent move so that a search can backtrack. Goal detection drives reached_o.
module maze_step_unit #(
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned STACK_DEPTH = 16,
    localparam int unsigned DepthW     = $clog2(STACK_DEPTH) + 1,
    localparam int unsigned PtrW       = $clog2(STACK_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [2*COORD_W-1:0] start_loc_i,
    input  logic [2*COORD_W-1:0] goal_loc_i,
    input  logic                 step_req_i,
    input  logic [1:0]           dir_i,
    input  logic                 pop_req_i,
    output logic [2*COORD_W-1:0] cur_loc_o,
    output logic                 ack_o,
    output logic [1:0]           err_o,
    output logic [DepthW-1:0]    depth_o,
    output logic                 reached_o
);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    localparam logic [1:0] ErrOk    = 2'b00;
    localparam logic [1:0] ErrEdge  = 2'b01;
    localparam logic [1:0] ErrFull  = 2'b10;
    localparam logic [1:0] ErrEmpty = 2'b11;
    localparam logic [DepthW-1:0] DepthFull = DepthW'(STACK_DEPTH);

    state_e               state_q, state_d;
    logic [2*COORD_W-1:0] cur_q, cur_d;
    logic [DepthW-1:0]    depth_q, depth_d;
    logic                 ack_q, ack_d;
    logic [1:0]           err_q, err_d;
    logic                 reached_q, reached_d;
    logic                 push_en;
    logic [1:0]           stack_q [STACK_DEPTH];
    logic [PtrW-1:0]      top_idx;
    logic [1:0]           top_dir;
    logic [2*COORD_W-1:0] step_loc, pop_loc;
    logic                 step_blocked;

    // dir[1]^dir[0] selects the X axis, dir[0] selects increment.
    function automatic logic move_blocked(input logic [2*COORD_W-1:0] loc, input logic [1:0] d);
        logic [COORD_W-1:0] c;
        c = (d[1] ^ d[0]) ? loc[2*COORD_W-1:COORD_W] : loc[COORD_W-1:0];
        return d[0] ? (c == '1) : (c == '0);
    endfunction

    function automatic logic [2*COORD_W-1:0] move_loc(input logic [2*COORD_W-1:0] loc,
                                                      input logic [1:0] d);
        logic [COORD_W-1:0] x, y;
        x = loc[2*COORD_W-1:COORD_W];
        y = loc[COORD_W-1:0];
        if (d[1] ^ d[0]) begin
            x = d[0] ? x + 1'b1 : x - 1'b1;
        end else begin
            y = d[0] ? y + 1'b1 : y - 1'b1;
        end
        return {x, y};
    endfunction

    always_comb begin
        top_idx      = PtrW'(depth_q - 1'b1);
        top_dir      = stack_q[top_idx];
        step_blocked = move_blocked(cur_q, dir_i);
        step_loc     = move_loc(cur_q, dir_i);
        // A recorded move is always reversible, so the undo needs no edge check.
        pop_loc      = move_loc(cur_q, top_dir ^ 2'b11);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        depth_d = depth_q;
        ack_d   = 1'b0;
        err_d   = ErrOk;
        push_en = 1'b0;
        if (load_i) begin
            cur_d   = start_loc_i;
            depth_d = '0;
            state_d = (start_loc_i == goal_loc_i) ? StDone : StActive;
        end else if (state_q != StIdle) begin
            if (pop_req_i) begin
                ack_d = 1'b1;
                if (depth_q == '0) begin
                    err_d = ErrEmpty;
                end else begin
                    cur_d   = pop_loc;
                    depth_d = depth_q - 1'b1;
                    state_d = (pop_loc == goal_loc_i) ? StDone : StActive;
                end
            end else if (step_req_i && state_q == StActive) begin
                ack_d = 1'b1;
                if (step_blocked) begin
                    err_d = ErrEdge;
                end else if (depth_q == DepthFull) begin
                    err_d = ErrFull;
                end else begin
                    cur_d   = step_loc;
                    depth_d = depth_q + 1'b1;
                    push_en = 1'b1;
                    state_d = (step_loc == goal_loc_i) ? StDone : StActive;
                end
            end
        end
        reached_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            depth_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= ErrOk;
            reached_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            depth_q   <= depth_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            reached_q <= reached_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            stack_q[depth_q[PtrW-1:0]] <= dir_i;
        end
    end

    assign cur_loc_o = cur_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign depth_o   = depth_q;
    assign reached_o = reached_q;

endmodule

// File: tb/tb_maze_step_unit.sv
// Directed bench for maze_step_unit: a default instance plus a STACK_DEPTH=4 instance
// sharing the same stimulus; outputs are sampled 1 ns after each rising edge.
module tb_maze_step_unit;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] start_loc;
    logic [7:0] goal_loc;
    logic       step_req;
    logic [1:0] dir;
    logic       pop_req;

    logic [7:0] cur_loc, cur_loc4;
    logic       ack, ack4;
    logic [1:0] err, err4;
    logic [4:0] depth;
    logic [2:0] depth4;
    logic       reached, reached4;

    int checks = 0;
    int errors = 0;

    logic [16:0] obs;
    logic [14:0] obs4;
    assign obs  = {cur_loc, ack, err, depth, reached};
    assign obs4 = {cur_loc4, ack4, err4, depth4, reached4};

    maze_step_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .start_loc_i(start_loc),
        .goal_loc_i(goal_loc), .step_req_i(step_req), .dir_i(dir), .pop_req_i(pop_req),
        .cur_loc_o(cur_loc), .ack_o(ack), .err_o(err), .depth_o(depth), .reached_o(reached)
    );

    maze_step_unit #(.STACK_DEPTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .start_loc_i(start_loc),
        .goal_loc_i(goal_loc), .step_req_i(step_req), .dir_i(dir), .pop_req_i(pop_req),
        .cur_loc_o(cur_loc4), .ack_o(ack4), .err_o(err4), .depth_o(depth4),
        .reached_o(reached4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] pk(input logic [7:0] c, input logic a, input logic [1:0] e,
                                       input logic [4:0] d, input logic r);
        return {c, a, e, d, r};
    endfunction

    function automatic logic [14:0] pk4(input logic [7:0] c, input logic a, input logic [1:0] e,
                                        input logic [2:0] d, input logic r);
        return {c, a, e, d, r};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] s, input logic [7:0] g);
        goal_loc  = g;
        start_loc = s;
        load      = 1'b1;
        cycle();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (obs !== pk(8'h00, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL reset_state: got {cur,ack,err,depth,reached}=%h required %h",
                     obs, pk(8'h00, 0, 2'b00, 0, 0));
        end
        #4 rst_n = 1'b1;
        step_req = 1'b1;
        dir      = 2'b01;
        cycle();
        checks++;
        if (obs !== pk(8'h00, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL idle_ignores_step: got %h required %h", obs, pk(8'h00, 0, 2'b00, 0, 0));
        end
        step_req = 1'b0;
        pop_req  = 1'b1;
        cycle();
        checks++;
        if (obs !== pk(8'h00, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL idle_ignores_pop: got %h required %h", obs, pk(8'h00, 0, 2'b00, 0, 0));
        end
        pop_req = 1'b0;
    endtask

    task automatic test_goal_steps();
        do_load(8'h11, 8'h31);
        checks++;
        if (obs !== pk(8'h11, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL goal_load: got %h required %h", obs, pk(8'h11, 0, 2'b00, 0, 0));
        end
        step_req = 1'b1;
        dir      = 2'b01;
        cycle();
        checks++;
        if (obs !== pk(8'h21, 1, 2'b00, 1, 0)) begin
            errors++;
            $display("FAIL goal_step1: got %h required %h", obs, pk(8'h21, 1, 2'b00, 1, 0));
        end
        cycle();
        checks++;
        if (obs !== pk(8'h31, 1, 2'b00, 2, 1)) begin
            errors++;
            $display("FAIL goal_step2: got %h required %h", obs, pk(8'h31, 1, 2'b00, 2, 1));
        end
        step_req = 1'b0;
        cycle();
        checks++;
        if (obs !== pk(8'h31, 0, 2'b00, 2, 1)) begin
            errors++;
            $display("FAIL goal_ack_clears: got %h required %h", obs, pk(8'h31, 0, 2'b00, 2, 1));
        end
        step_req = 1'b1;
        cycle();
        checks++;
        if (obs !== pk(8'h31, 0, 2'b00, 2, 1)) begin
            errors++;
            $display("FAIL done_ignores_step: got %h required %h", obs, pk(8'h31, 0, 2'b00, 2, 1));
        end
        step_req = 1'b0;
    endtask

    task automatic test_edges();
        do_load(8'h00, 8'h77);
        step_req = 1'b1;
        dir      = 2'b00;
        cycle();
        checks++;
        if (obs !== pk(8'h00, 1, 2'b01, 0, 0)) begin
            errors++;
            $display("FAIL edge_y_minus: got %h required %h", obs, pk(8'h00, 1, 2'b01, 0, 0));
        end
        dir = 2'b10;
        cycle();
        checks++;
        if (obs !== pk(8'h00, 1, 2'b01, 0, 0)) begin
            errors++;
            $display("FAIL edge_x_minus: got %h required %h", obs, pk(8'h00, 1, 2'b01, 0, 0));
        end
        step_req = 1'b0;
        do_load(8'hff, 8'h77);
        checks++;
        if (obs !== pk(8'hff, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL edge_load_max: got %h required %h", obs, pk(8'hff, 0, 2'b00, 0, 0));
        end
        step_req = 1'b1;
        dir      = 2'b11;
        cycle();
        checks++;
        if (obs !== pk(8'hff, 1, 2'b01, 0, 0)) begin
            errors++;
            $display("FAIL edge_y_plus: got %h required %h", obs, pk(8'hff, 1, 2'b01, 0, 0));
        end
        dir = 2'b01;
        cycle();
        checks++;
        if (obs !== pk(8'hff, 1, 2'b01, 0, 0)) begin
            errors++;
            $display("FAIL edge_x_plus: got %h required %h", obs, pk(8'hff, 1, 2'b01, 0, 0));
        end
        step_req = 1'b0;
    endtask

    task automatic test_backtrack();
        logic [7:0] step_exp [3];
        logic [1:0] step_dir [3];
        logic [7:0] pop_exp  [3];
        step_dir = '{2'b01, 2'b11, 2'b10};
        step_exp = '{8'h65, 8'h66, 8'h56};
        pop_exp  = '{8'h66, 8'h65, 8'h55};
        do_load(8'h55, 8'h77);
        step_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dir = step_dir[i];
            cycle();
            checks++;
            if (obs !== pk(step_exp[i], 1, 2'b00, 5'(i + 1), 0)) begin
                errors++;
                $display("FAIL backtrack_step%0d: got %h required %h", i, obs,
                         pk(step_exp[i], 1, 2'b00, 5'(i + 1), 0));
            end
        end
        step_req = 1'b0;
        pop_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs !== pk(pop_exp[i], 1, 2'b00, 5'(2 - i), 0)) begin
                errors++;
                $display("FAIL backtrack_pop%0d: got %h required %h", i, obs,
                         pk(pop_exp[i], 1, 2'b00, 5'(2 - i), 0));
            end
        end
        cycle();
        checks++;
        if (obs !== pk(8'h55, 1, 2'b11, 0, 0)) begin
            errors++;
            $display("FAIL pop_empty: got %h required %h", obs, pk(8'h55, 1, 2'b11, 0, 0));
        end
        pop_req = 1'b0;
    endtask

    task automatic test_full();
        do_load(8'h00, 8'hff);
        step_req = 1'b1;
        dir      = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            checks++;
            if (obs4 !== pk4(8'(i << 4), 1, 2'b00, 3'(i), 0)) begin
                errors++;
                $display("FAIL full_step%0d: got %h required %h", i, obs4,
                         pk4(8'(i << 4), 1, 2'b00, 3'(i), 0));
            end
        end
        cycle();
        checks++;
        if (obs4 !== pk4(8'h40, 1, 2'b10, 4, 0)) begin
            errors++;
            $display("FAIL full_fifth: got %h required %h", obs4, pk4(8'h40, 1, 2'b10, 4, 0));
        end
        step_req = 1'b0;
    endtask

    task automatic test_priority();
        do_load(8'h00, 8'hff);
        step_req = 1'b1;
        dir      = 2'b01;
        cycle();
        cycle();
        checks++;
        if (obs !== pk(8'h20, 1, 2'b00, 2, 0)) begin
            errors++;
            $display("FAIL prio_setup: got %h required %h", obs, pk(8'h20, 1, 2'b00, 2, 0));
        end
        start_loc = 8'h33;
        load      = 1'b1;
        pop_req   = 1'b1;
        cycle();
        checks++;
        if (obs !== pk(8'h33, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL prio_load_wins: got %h required %h", obs, pk(8'h33, 0, 2'b00, 0, 0));
        end
        load    = 1'b0;
        pop_req = 1'b0;
        cycle();
        checks++;
        if (obs !== pk(8'h43, 1, 2'b00, 1, 0)) begin
            errors++;
            $display("FAIL prio_step_after: got %h required %h", obs, pk(8'h43, 1, 2'b00, 1, 0));
        end
        pop_req = 1'b1;
        cycle();
        checks++;
        if (obs !== pk(8'h33, 1, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL prio_pop_wins: got %h required %h", obs, pk(8'h33, 1, 2'b00, 0, 0));
        end
        pop_req  = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic test_pop_done();
        do_load(8'h12, 8'h12);
        checks++;
        if (obs !== pk(8'h12, 0, 2'b00, 0, 1)) begin
            errors++;
            $display("FAIL load_at_goal: got %h required %h", obs, pk(8'h12, 0, 2'b00, 0, 1));
        end
        do_load(8'h11, 8'h12);
        step_req = 1'b1;
        dir      = 2'b11;
        cycle();
        checks++;
        if (obs !== pk(8'h12, 1, 2'b00, 1, 1)) begin
            errors++;
            $display("FAIL done_by_y_plus: got %h required %h", obs, pk(8'h12, 1, 2'b00, 1, 1));
        end
        step_req = 1'b0;
        pop_req  = 1'b1;
        cycle();
        checks++;
        if (obs !== pk(8'h11, 1, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL pop_leaves_done: got %h required %h", obs, pk(8'h11, 1, 2'b00, 0, 0));
        end
        pop_req = 1'b0;
    endtask

    task automatic test_async_reset();
        do_load(8'h00, 8'hff);
        step_req = 1'b1;
        dir      = 2'b01;
        cycle();
        cycle();
        step_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== pk(8'h00, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", obs, pk(8'h00, 0, 2'b00, 0, 0));
        end
        #2 rst_n = 1'b1;
        step_req = 1'b1;
        cycle();
        checks++;
        if (obs !== pk(8'h00, 0, 2'b00, 0, 0)) begin
            errors++;
            $display("FAIL post_reset_idle: got %h required %h", obs, pk(8'h00, 0, 2'b00, 0, 0));
        end
        step_req = 1'b0;
    endtask

    initial begin
        load      = 1'b0;
        start_loc = 8'h00;
        goal_loc  = 8'h00;
        step_req  = 1'b0;
        dir       = 2'b00;
        pop_req   = 1'b0;
        test_reset();
        test_goal_steps();
        test_edges();
        test_backtrack();
        test_full();
        test_priority();
        test_pop_done();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
